// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and BCD digit limits.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;  // su, mu wrap target
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;  // st wrap target
    localparam int         MAX_MIN_T_DEF = 9;     // default largest minutes-tens digit

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chained down-counter. With borrow_in high the
// digit steps down by one; from zero it wraps to the supplied limit and
// passes the borrow on to the next more-significant digit.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic [3:0] limit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    // Decrement-with-wrap for a single digit.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = limit;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with load/start/pause/clear strobes and a 1 Hz tick.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | count is 00:00, waiting for a nonzero load
//   ST_READY  | nonzero value loaded, waiting for start
//   ST_RUN    | counting down one second per tick
//   ST_PAUSED | count frozen, start resumes
//   ST_DONE   | count reached 00:00 by ticking; done pulses on entry
//
// Only the highest-priority asserted strobe is considered in a cycle
// (clear > load > pause > start > tick); if that strobe has no effect in the
// current state the cycle is a no-op.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN_T = MAX_MIN_T_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_mt,
    input  logic [3:0] ld_mu,
    input  logic [3:0] ld_st,
    input  logic [3:0] ld_su,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] mt,
    output logic [3:0] mu,
    output logic [3:0] st,
    output logic [3:0] su,
    output logic       running,
    output logic       done,
    output logic       zero
);

    localparam logic [3:0] MT_LIM = 4'(MAX_MIN_T);

    state_t     state_q, state_d;
    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic [3:0] mt_d, mu_d, st_d, su_d;
    logic       done_q, done_d;

    logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
    logic       b_su, b_st, b_mu, b_mt;
    logic       ld_valid, ld_zero, dec_zero;

    bcd_digit_dec u_dec_su (.digit(su_q), .limit(BCD_MAX_UNITS), .borrow_in(1'b1),
                            .digit_next(dec_su), .borrow_out(b_su));
    bcd_digit_dec u_dec_st (.digit(st_q), .limit(BCD_MAX_TENS), .borrow_in(b_su),
                            .digit_next(dec_st), .borrow_out(b_st));
    bcd_digit_dec u_dec_mu (.digit(mu_q), .limit(BCD_MAX_UNITS), .borrow_in(b_st),
                            .digit_next(dec_mu), .borrow_out(b_mu));
    bcd_digit_dec u_dec_mt (.digit(mt_q), .limit(MT_LIM), .borrow_in(b_mu),
                            .digit_next(dec_mt), .borrow_out(b_mt));

    assign ld_valid = (ld_mt <= MT_LIM) && (ld_mu <= BCD_MAX_UNITS) &&
                      (ld_st <= BCD_MAX_TENS) && (ld_su <= BCD_MAX_UNITS);
    assign ld_zero  = ({ld_mt, ld_mu, ld_st, ld_su} == 16'h0000);
    assign dec_zero = ({dec_mt, dec_mu, dec_st, dec_su} == 16'h0000);

    // Next-state and next-count selection by strobe priority.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        st_d    = st_q;
        su_d    = su_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            mt_d    = 4'd0;
            mu_d    = 4'd0;
            st_d    = 4'd0;
            su_d    = 4'd0;
        end else if (load) begin
            if (state_q != ST_RUN && ld_valid) begin
                mt_d    = ld_mt;
                mu_d    = ld_mu;
                st_d    = ld_st;
                su_d    = ld_su;
                state_d = ld_zero ? ST_IDLE : ST_READY;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start) begin
            if (state_q == ST_READY || state_q == ST_PAUSED) begin
                state_d = ST_RUN;
            end
        end else if (tick) begin
            // A borrow out of the top digit means the count is already 00:00;
            // suppressing the update keeps the count from wrapping.
            if (state_q == ST_RUN && !b_mt) begin
                mt_d = dec_mt;
                mu_d = dec_mu;
                st_d = dec_st;
                su_d = dec_su;
                if (dec_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // State, count and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mt_q    <= 4'd0;
            mu_q    <= 4'd0;
            st_q    <= 4'd0;
            su_q    <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            st_q    <= st_d;
            su_q    <= su_d;
            done_q  <= done_d;
        end
    end

    assign mt      = mt_q;
    assign mu      = mu_q;
    assign st      = st_q;
    assign su      = su_q;
    assign done    = done_q;
    assign running = (state_q == ST_RUN);
    assign zero    = ({mt_q, mu_q, st_q, su_q} == 16'h0000);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: hand-computed counts, flags and states.
module tb_countdown_timer;
    import timer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tick, load, start, pause, clear;
    logic [3:0] ld_mt, ld_mu, ld_st, ld_su;
    logic [3:0] mt, mu, st, su;
    logic       running, done, zero;

    int n_checks = 0;
    int n_errors = 0;

    countdown_timer #(.MAX_MIN_T(9)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .ld_mt(ld_mt), .ld_mu(ld_mu), .ld_st(ld_st), .ld_su(ld_su),
        .start(start), .pause(pause), .clear(clear),
        .mt(mt), .mu(mu), .st(st), .su(su),
        .running(running), .done(done), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt();
        return {mt, mu, st, su};
    endfunction

    function automatic logic [15:0] st_now();
        return 16'(dut.state_q);
    endfunction

    task automatic set_ld(input logic [15:0] v);
        {ld_mt, ld_mu, ld_st, ld_su} = v;
    endtask

    // Drive one cycle of strobes at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic t, input logic ld, input logic sa, input logic pa, input logic cl);
        @(negedge clk);
        tick = t; load = ld; start = sa; pause = pa; clear = cl;
        @(posedge clk);
        #1;
        tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        tick = 0; load = 0; start = 0; pause = 0; clear = 0;
        set_ld(16'h0000);
        #12;
        check_val("rst_count", cnt(), 16'h0000);
        check_val("rst_running", 16'(running), 16'd0);
        check_val("rst_done", 16'(done), 16'd0);
        check_val("rst_zero", 16'(zero), 16'd1);
        check_val("rst_state", st_now(), 16'(ST_IDLE));
        @(negedge clk);
        rst_n = 1;
        step(1, 0, 0, 0, 0);
        check_val("idle_tick", cnt(), 16'h0000);

        // 00:03 runs down to DONE
        set_ld(16'h0003);
        step(0, 1, 0, 0, 0);
        check_val("ld3_count", cnt(), 16'h0003);
        check_val("ld3_state", st_now(), 16'(ST_READY));
        check_val("ld3_zero", 16'(zero), 16'd0);
        step(0, 0, 1, 0, 0);
        check_val("start_running", 16'(running), 16'd1);
        step(1, 0, 0, 0, 0);
        check_val("t1_count", cnt(), 16'h0002);
        step(1, 0, 0, 0, 0);
        check_val("t2_count", cnt(), 16'h0001);
        check_val("t2_done", 16'(done), 16'd0);
        step(1, 0, 0, 0, 0);
        check_val("t3_count", cnt(), 16'h0000);
        check_val("t3_done", 16'(done), 16'd1);
        check_val("t3_state", st_now(), 16'(ST_DONE));
        check_val("t3_running", 16'(running), 16'd0);
        check_val("t3_zero", 16'(zero), 16'd1);
        step(1, 0, 0, 0, 0);
        check_val("done_pulse_end", 16'(done), 16'd0);
        check_val("done_tick_cnt", cnt(), 16'h0000);
        check_val("done_hold", st_now(), 16'(ST_DONE));
        step(0, 0, 1, 0, 0);
        check_val("done_start", st_now(), 16'(ST_DONE));

        // 10:00 borrows across all digits; load during RUN is ignored
        set_ld(16'h1000);
        step(0, 1, 0, 0, 0);
        check_val("ld1000", cnt(), 16'h1000);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("borrow_0959", cnt(), 16'h0959);
        set_ld(16'h0500);
        step(0, 1, 0, 0, 0);
        check_val("run_load_cnt", cnt(), 16'h0959);
        check_val("run_load_state", st_now(), 16'(ST_RUN));
        step(0, 0, 0, 0, 1);
        check_val("clear_cnt", cnt(), 16'h0000);
        check_val("clear_state", st_now(), 16'(ST_IDLE));

        // Pause freezes the count through ticks, start resumes
        set_ld(16'h0005);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("pre_pause", cnt(), 16'h0003);
        step(0, 0, 0, 1, 0);
        check_val("pause_state", st_now(), 16'(ST_PAUSED));
        check_val("pause_running", 16'(running), 16'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        check_val("paused_hold", cnt(), 16'h0003);
        step(0, 0, 1, 0, 0);
        check_val("resume_state", st_now(), 16'(ST_RUN));
        check_val("resume_cnt", cnt(), 16'h0003);
        step(1, 0, 0, 0, 0);
        check_val("resume_tick", cnt(), 16'h0002);

        // Invalid and zero loads
        step(0, 0, 0, 1, 0);
        set_ld(16'h0102);
        step(0, 1, 0, 0, 0);
        check_val("ld0102", cnt(), 16'h0102);
        set_ld(16'h0160);
        step(0, 1, 0, 0, 0);
        check_val("bad_st_cnt", cnt(), 16'h0102);
        check_val("bad_st_state", st_now(), 16'(ST_READY));
        set_ld(16'hA000);
        step(0, 1, 0, 0, 0);
        check_val("bad_mt_cnt", cnt(), 16'h0102);
        set_ld(16'h0959);
        step(0, 1, 0, 0, 0);
        check_val("max_sec_ld", cnt(), 16'h0959);
        set_ld(16'h0000);
        step(0, 1, 0, 0, 0);
        check_val("ld0_state", st_now(), 16'(ST_IDLE));
        check_val("ld0_zero", 16'(zero), 16'd1);
        step(0, 0, 1, 0, 0);
        check_val("ld0_start", st_now(), 16'(ST_IDLE));
        check_val("ld0_done", 16'(done), 16'd0);
        step(1, 0, 0, 0, 0);
        check_val("ld0_tick_done", 16'(done), 16'd0);

        // Tick coinciding with start is dropped; 00:10 -> 00:09
        set_ld(16'h0010);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check_val("start_tick_st", st_now(), 16'(ST_RUN));
        check_val("start_tick_cnt", cnt(), 16'h0010);
        step(1, 0, 0, 0, 0);
        check_val("borrow_0009", cnt(), 16'h0009);

        // clear beats load and start in RUN
        set_ld(16'h0300);
        step(0, 1, 1, 0, 1);
        check_val("prio_cnt", cnt(), 16'h0000);
        check_val("prio_state", st_now(), 16'(ST_IDLE));

        // Asynchronous reset mid-RUN at 01:30
        set_ld(16'h0130);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_val("pre_rst_cnt", cnt(), 16'h0130);
        #2;
        rst_n = 0;
        #1;
        check_val("arst_cnt", cnt(), 16'h0000);
        check_val("arst_state", st_now(), 16'(ST_IDLE));
        check_val("arst_running", 16'(running), 16'd0);
        check_val("arst_zero", 16'(zero), 16'd1);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check_val("post_rst_cnt", cnt(), 16'h0000);
        step(0, 0, 1, 0, 0);
        check_val("post_rst_state", st_now(), 16'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter MAX_MIN_T, default 9, giving the largest legal minutes-tens digit.
REQ-002 The block SHALL have ports, in this order:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle 1 Hz enable pulse, synchronous to clk
- load  in  1  one-cycle strobe that captures ld_mt/ld_mu/ld_st/ld_su
- ld_mt, ld_mu, ld_st, ld_su  in  4 each  BCD load value mm:ss (minutes tens/units, seconds tens/units)
- start  in  1  one-cycle strobe that begins or resumes counting
- pause  in  1  one-cycle strobe that suspends counting
- clear  in  1  one-cycle strobe that zeroes the count and returns to IDLE
- mt, mu, st, su  out  4 each  current BCD count, registered; feeds the display select mux
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse on expiry
- zero  out  1  high when the count is 00:00

Function
REQ-003 The block SHALL implement states IDLE, READY, RUN, PAUSED and DONE.
REQ-004 Strobe priority when asserted in the same cycle SHALL be clear > load > pause > start > tick.
REQ-005 clear SHALL set the count to 00:00 and the state to IDLE from any state.
REQ-006 load with a valid value SHALL update the count at the next edge and go to READY if the value is nonzero, or to IDLE if it is zero; this applies from IDLE, READY, PAUSED and DONE.
REQ-007 load SHALL be ignored in RUN.
REQ-008 A load value is valid only if ld_mt<=MAX_MIN_T, ld_mu<=9, ld_st<=5 and ld_su<=9; an invalid load SHALL be ignored, leaving count and state unchanged.
REQ-009 start SHALL move READY or PAUSED to RUN; start in IDLE, DONE or RUN SHALL have no effect.
REQ-010 pause SHALL move RUN to PAUSED with the count frozen; pause in any other state SHALL have no effect.
REQ-011 tick SHALL decrement the count by one second only in RUN, and a tick in the same cycle as an accepted start SHALL be ignored.
REQ-012 Decrement SHALL borrow su->st->mu->mt, with st wrapping 0->5 and su/mu wrapping 0->9 (e.g. 10:00 -> 09:59).
REQ-013 The count SHALL be non-recycling: it never wraps below 00:00 and never goes above the loaded value.
REQ-014 The tick that produces 00:00 SHALL move the state to DONE at the same edge, and done SHALL be high for exactly the first cycle in DONE.
REQ-015 In DONE, ticks SHALL be ignored, and the state SHALL remain DONE until clear or load.
REQ-016 running SHALL equal (state==RUN); zero SHALL equal (count==00:00); both SHALL be combinational from registers.
REQ-017 Latency from any strobe to the output change SHALL be one clock edge.
REQ-018 Outputs SHALL never show a non-BCD digit.

Reset
REQ-019 Assertion of rst_n low SHALL immediately force state IDLE, count 00:00, running=0, done=0 and zero=1, asynchronously to clk.
REQ-020 Reset mid-count SHALL discard the count; after release the block SHALL stay in IDLE until a load is accepted.
REQ-021 Deassertion of rst_n SHALL take effect at the first rising clk edge after release.

Structure
REQ-022 Package timer_pkg SHALL hold the state encoding, BCD limit constants (9, 5) and the MAX_MIN_T default.
REQ-023 The sub-module bcd_digit_dec SHALL provide one-digit decrement with a wrap limit input and borrow-in/borrow-out, instantiated four times in a chain.
REQ-024 The FSM and count registers SHALL reside in countdown_timer; no other sub-modules are permitted.

Verification
REQ-025 Load 00:03, start, three ticks -> count 00:02, 00:01, 00:00; done high exactly one cycle after the third tick edge; state DONE.
REQ-026 Load 10:00, start, one tick -> count 09:59; load during RUN -> ignored, count unchanged.
REQ-027 Load 00:05, start, two ticks, pause, five ticks, start, one tick -> counts 00:03 held through the pause, then 00:02.
REQ-028 Load ld_st=6 -> count and state unchanged; load 00:00 then start -> state IDLE, done never asserted.
REQ-029 clear, load and start in the same cycle while in RUN -> IDLE with count 00:00.
REQ-030 rst_n low mid-RUN at 01:30 -> immediate 00:00, IDLE, running=0; after release, ticks cause no change.
